// File: rtl/fixed_point_converter_pipe.sv
// Fixed-point format converter: re-align, round half up, saturate or wrap, overflow flag/count.
// Two register stages, 2-cycle latency; valid/ready back-pressure, full rate with no bubble.
module fixed_point_converter_pipe #(
  parameter int IN_W     = 16,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 8,
  parameter int OUT_FRAC = 4,
  parameter int SIGNED   = 1,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int IN_INT   = IN_W - IN_FRAC;
  localparam int OUT_INT  = OUT_W - OUT_FRAC;
  localparam int INT_MAX  = (IN_INT > OUT_INT) ? IN_INT : OUT_INT;
  localparam int FRAC_MAX = (IN_FRAC > OUT_FRAC) ? IN_FRAC : OUT_FRAC;
  // Two guard bits keep the sign and the rounding carry from wrapping.
  localparam int IW       = INT_MAX + 2 + FRAC_MAX;
  localparam int SH_L     = (OUT_FRAC > IN_FRAC) ? (OUT_FRAC - IN_FRAC) : 0;
  localparam int SH_R     = (IN_FRAC > OUT_FRAC) ? (IN_FRAC - OUT_FRAC) : 0;

  localparam logic signed [IW-1:0] RND =
    (ROUND != 0 && SH_R > 0) ? (IW'(1) << ((SH_R > 0) ? (SH_R - 1) : 0)) : '0;
  localparam logic signed [IW-1:0] MAXV =
    (IW'(1) << ((SIGNED != 0) ? (OUT_W - 1) : OUT_W)) - IW'(1);
  localparam logic signed [IW-1:0] MINV =
    (SIGNED != 0) ? -(IW'(1) << (OUT_W - 1)) : '0;

  logic                 s1_valid;
  logic signed [IW-1:0] s1_data;
  logic                 s2_can_load;
  logic                 sext;
  logic signed [IW-1:0] ext;
  logic signed [IW-1:0] aligned;
  logic                 above;
  logic                 below;
  logic [OUT_W-1:0]     nxt_data;
  logic                 out_xfer;

  assign s2_can_load = out_ready | ~out_valid;
  assign in_ready    = ~s1_valid | s2_can_load;
  assign out_xfer    = out_valid & out_ready;

  assign sext = (SIGNED != 0) && in_data[IN_W-1];
  assign ext  = {{(IW-IN_W){sext}}, in_data};

  // Only one of SH_R / SH_L is ever non-zero; >>> on the signed sum floors.
  always_comb begin
    aligned = ((ext + RND) >>> SH_R) <<< SH_L;
  end

  always_comb begin
    above    = s1_data > MAXV;
    below    = s1_data < MINV;
    nxt_data = s1_data[OUT_W-1:0];
    if (SATURATE != 0) begin
      if (above)      nxt_data = MAXV[OUT_W-1:0];
      else if (below) nxt_data = MINV[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= aligned;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (s2_can_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= nxt_data;
        out_ovf  <= above | below;
      end
    end
  end

  // clear wins over a coincident overflow, which is then not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (clear) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (out_xfer && out_ovf) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != {CNT_W{1'b1}}) ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule
